// File: rtl/pcpi_issuer.sv
// PCPI initiator: offers one core request to a coprocessor, waits for its result
// (or traps when nobody claims the instruction) and returns it on a response port.
module pcpi_issuer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_trap,
    output logic [15:0] rsp_cycles,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] TO_CYC  = 16'(TIMEOUT_CYCLES);

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
    // valid and its payload stay stable until that edge.

    logic [1:0]  state_q, state_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [15:0] cnt_q, cnt_d;
    logic        seen_wait_q, seen_wait_d;
    logic [31:0] rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        trap_q, trap_d;
    logic [15:0] cycles_q, cycles_d;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        insn_d      = insn_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        cnt_d       = cnt_q;
        seen_wait_d = seen_wait_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        trap_d      = trap_q;
        cycles_d    = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    insn_d      = req_insn;
                    rs1_d       = req_rs1;
                    rs2_d       = req_rs2;
                    cnt_d       = 16'd0;
                    seen_wait_d = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (pcpi_wait) seen_wait_d = 1'b1;
                // A result arriving in the last allowed cycle beats the timeout.
                if (pcpi_ready) begin
                    rd_d     = pcpi_rd;
                    wr_d     = pcpi_wr;
                    trap_d   = 1'b0;
                    cycles_d = cnt_inc;
                    state_d  = S_RESP;
                end else if (cnt_q == TO_LAST && !pcpi_wait && !seen_wait_q) begin
                    rd_d     = 32'd0;
                    wr_d     = 1'b0;
                    trap_d   = 1'b1;
                    cycles_d = TO_CYC;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            insn_q      <= 32'd0;
            rs1_q       <= 32'd0;
            rs2_q       <= 32'd0;
            cnt_q       <= 16'd0;
            seen_wait_q <= 1'b0;
            rd_q        <= 32'd0;
            wr_q        <= 1'b0;
            trap_q      <= 1'b0;
            cycles_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            insn_q      <= insn_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            cnt_q       <= cnt_d;
            seen_wait_q <= seen_wait_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            trap_q      <= trap_d;
            cycles_q    <= cycles_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign pcpi_valid = (state_q == S_ISSUE);
    assign rsp_valid  = (state_q == S_RESP);
    assign pcpi_insn  = insn_q;
    assign pcpi_rs1   = rs1_q;
    assign pcpi_rs2   = rs2_q;
    assign rsp_rd     = rd_q;
    assign rsp_wr     = wr_q;
    assign rsp_trap   = trap_q;
    assign rsp_cycles = cycles_q;

endmodule

// File: tb/tb_pcpi_issuer.sv
// Directed bench for pcpi_issuer: coprocessor model, request driver and a
// scoreboard that checks each response as it is consumed.
module tb_pcpi_issuer;

    localparam int TO = 16;
    localparam int W  = 50;  // {rd[31:0], wr, trap, cycles[15:0]}

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_insn = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_trap;
    logic [15:0] rsp_cycles;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_wait = 1'b0;
    logic        pcpi_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // coprocessor model configuration (ISSUE cycles are numbered from 1)
    int          w_lo = 100, w_hi = 0, r_cyc = 0;
    logic [31:0] r_rd = '0;
    logic        r_wr = 1'b0;
    int          cyc = 0, last_hi = 0;
    logic        prev_valid = 1'b0, prev_rdy = 1'b0;
    logic [95:0] cur_req = '0;

    pcpi_issuer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_trap(rsp_trap), .rsp_cycles(rsp_cycles),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end required end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // coprocessor model: drives wait/ready per ISSUE cycle, junk otherwise
    always @(negedge clk) begin
        if (prev_rdy) begin
            checks++;
            if (pcpi_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_after_ready: pcpi_valid=%b required 0", pcpi_valid);
            end
        end
        if (pcpi_valid === 1'b1) begin
            cyc = prev_valid ? cyc + 1 : 1;
            last_hi = cyc;
            checks++;
            if ({pcpi_insn, pcpi_rs1, pcpi_rs2} !== cur_req) begin
                errors++;
                $display("FAIL pcpi_operands: got %h required %h",
                         {pcpi_insn, pcpi_rs1, pcpi_rs2}, cur_req);
            end
            pcpi_wait  = (cyc >= w_lo && cyc <= w_hi);
            pcpi_ready = (cyc == r_cyc);
            pcpi_rd    = pcpi_ready ? r_rd : 32'hDEADBEEF;
            pcpi_wr    = pcpi_ready ? r_wr : 1'b1;
        end else begin
            pcpi_wait  = 1'b0;
            pcpi_ready = 1'b0;
            pcpi_rd    = 32'h5A5A5A5A;
            pcpi_wr    = 1'b1;
        end
        prev_rdy   = (pcpi_valid === 1'b1) && pcpi_ready;
        prev_valid = (pcpi_valid === 1'b1);
    end

    // scoreboard monitor
    logic [W-1:0] snap;
    logic [W-1:0] e;
    logic         hold = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL req_ready_in_resp: got %b required 0", req_ready);
            end
            if (hold) begin
                checks++;
                if ({rsp_rd, rsp_wr, rsp_trap, rsp_cycles} !== snap) begin
                    errors++;
                    $display("FAIL rsp_hold: got %h required %h",
                             {rsp_rd, rsp_wr, rsp_trap, rsp_cycles}, snap);
                end
            end
            snap = {rsp_rd, rsp_wr, rsp_trap, rsp_cycles};
            if (rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got %h required none", snap);
                end else begin
                    e = exp_q.pop_front();
                    if (snap !== e) begin
                        errors++;
                        $display("FAIL rsp_fields: got rd=%h wr=%b trap=%b cyc=%0d required rd=%h wr=%b trap=%b cyc=%0d",
                                 snap[49:18], snap[17], snap[16], snap[15:0],
                                 e[49:18], e[17], e[16], e[15:0]);
                    end
                    checks++;
                    if (last_hi != int'(e[15:0])) begin
                        errors++;
                        $display("FAIL valid_hi_cycles: got %0d required %0d", last_hi, e[15:0]);
                    end
                end
                hold = 1'b0;
            end else begin
                hold = 1'b1;
            end
        end else begin
            hold = 1'b0;
        end
    end

    // driver tasks
    task automatic set_cop(input int lo, input int hi, input int rc,
                           input logic [31:0] rd, input logic wr);
        w_lo = lo; w_hi = hi; r_cyc = rc; r_rd = rd; r_wr = wr;
    endtask

    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic push, input logic [W-1:0] exp);
        int n;
        req_insn = insn; req_rs1 = rs1; req_rs2 = rs2; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        cur_req = {insn, rs1, rs2};
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (push) exp_q.push_back(exp);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        #12;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_pcpi_valid", 64'(pcpi_valid), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp", 64'({rsp_rd, rsp_wr, rsp_trap, rsp_cycles}), 64'd0);
        chk("reset_pcpi_data", 64'(pcpi_insn | pcpi_rs1 | pcpi_rs2), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // DIV claimed with wait, result in cycle 4
        set_cop(1, 3, 4, 32'd6, 1'b1);
        issue(32'h0200C433, 32'd20, 32'd3, 1'b1, {32'd6, 1'b1, 1'b0, 16'd4});
        wait_done();

        // unclaimed instruction times out
        set_cop(100, 0, 0, 32'h0, 1'b0);
        issue(32'h0000000B, 32'd1, 32'd2, 1'b1, {32'd0, 1'b0, 1'b1, 16'd16});
        wait_done();

        // wait pulse in cycle 2 only disables timeout; result in cycle 40
        set_cop(2, 2, 40, 32'hFFFFFFFF, 1'b1);
        issue(32'h0220C533, 32'h12345678, 32'h9ABCDEF0, 1'b1, {32'hFFFFFFFF, 1'b1, 1'b0, 16'd40});
        wait_done();

        // ready in the timeout cycle wins
        set_cop(100, 0, 16, 32'h80000000, 1'b0);
        issue(32'h0230D633, 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 1'b0, 1'b0, 16'd16});
        wait_done();

        // back-pressure with a second request waiting
        set_cop(100, 0, 3, 32'h00001234, 1'b1);
        rsp_ready = 1'b0;
        issue(32'h02208733, 32'd7, 32'd9, 1'b1, {32'h00001234, 1'b1, 1'b0, 16'd3});
        req_insn = 32'h022097B3; req_rs1 = 32'd11; req_rs2 = 32'd13; req_valid = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        issue(32'h022097B3, 32'd11, 32'd13, 1'b1, {32'h00001234, 1'b1, 1'b0, 16'd3});
        wait_done();

        // reset in ISSUE cycle 3 aborts without a response
        set_cop(100, 0, 99, 32'h0, 1'b0);
        issue(32'h02A5C833, 32'd5, 32'd6, 1'b0, '0);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (cyc != 3 && n < 20);
        chk("rst_reached_cycle3", 64'(cyc), 64'd3);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_pcpi_valid", 64'(pcpi_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp", 64'({rsp_rd, rsp_wr, rsp_trap, rsp_cycles}), 64'd0);
        chk("rst_pcpi_insn", 64'(pcpi_insn), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        set_cop(100, 0, 2, 32'hCAFE0001, 1'b1);
        issue(32'h02B5D8B3, 32'd100, 32'd7, 1'b1, {32'hCAFE0001, 1'b1, 1'b0, 16'd2});
        wait_done();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
